// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one stretched-pulse output among NREQ requesters.
// Optional post-pulse idle gap enabled by defining PULSE_ARB_GAP_EN.
module pulse_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 25,
    parameter int GAP  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   dur,
    output logic [NREQ-1:0]      ack,
    output logic                 pulse_out,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic                 done
);

    localparam int LW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || GAP < 1) begin : g_param_check
        $error("pulse_arbiter: NREQ must be 2..8 and GAP at least 1");
    end

`ifdef PULSE_ARB_GAP_EN
    localparam int GW = $clog2(GAP + 1);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PULSE = 2'd1, ST_GAP = 2'd2} state_t;
    logic [GW-1:0] gap_cnt_r;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PULSE = 2'd1} state_t;
`endif

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [LW-1:0]  last_r;

    logic           grant_valid_s;
    logic [LW-1:0]  grant_idx_s;
    logic [LW-1:0]  cand_s;
    logic [CW-1:0]  grant_raw_s;
    logic [CW-1:0]  grant_dur_s;

    // Round-robin search starting one past the last owner, wrapping modulo NREQ.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = LW'((int'(last_r) + k) % NREQ);
            if (!grant_valid_s && req[cand_s]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Duration of the granted requester; a zero field still yields a one-cycle pulse.
    always_comb begin
        grant_raw_s = dur[grant_idx_s*CW +: CW];
        if (grant_raw_s == '0) begin
            grant_dur_s = CW'(1);
        end else begin
            grant_dur_s = grant_raw_s;
        end
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            last_r    <= LW'(NREQ - 1);
            ack       <= '0;
            pulse_out <= 1'b0;
            owner     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PULSE_ARB_GAP_EN
            gap_cnt_r <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (grant_valid_s) begin
                        ack       <= NREQ'(1) << grant_idx_s;
                        owner     <= 3'(grant_idx_s);
                        last_r    <= grant_idx_s;
                        cnt_r     <= grant_dur_s;
                        pulse_out <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_PULSE;
                    end else begin
                        ack <= '0;
                    end
                end
                ST_PULSE: begin
                    ack <= '0;
                    if (cnt_r > CW'(1)) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else begin
                        pulse_out <= 1'b0;
                        done      <= 1'b1;
                        cnt_r     <= '0;
`ifdef PULSE_ARB_GAP_EN
                        gap_cnt_r <= GW'(GAP);
                        state_r   <= ST_GAP;
`else
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
`endif
                    end
                end
`ifdef PULSE_ARB_GAP_EN
                ST_GAP: begin
                    done <= 1'b0;
                    ack  <= '0;
                    if (gap_cnt_r > GW'(1)) begin
                        gap_cnt_r <= gap_cnt_r - GW'(1);
                    end else begin
                        gap_cnt_r <= '0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    ack       <= '0;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed self-checking bench for pulse_arbiter (NREQ=4, GAP=4).
module tb_pulse_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 25;
`ifdef PULSE_ARB_GAP_EN
    localparam logic GAP_ON = 1'b1;
`else
    localparam logic GAP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*CW-1:0] dur = '0;
    logic [NREQ-1:0]   ack;
    logic              pulse_out;
    logic [2:0]        owner;
    logic              busy;
    logic              done;

    int total_cnt = 0;
    int bad_cnt   = 0;

    pulse_arbiter #(.NREQ(NREQ), .CW(CW), .GAP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dur       (dur),
        .ack       (ack),
        .pulse_out (pulse_out),
        .owner     (owner),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int d0, input int d1, input int d2, input int d3);
        dur = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] stray_ack;
        int phase;
        int exp_g;

        // Reset state
        do_reset();
        check_val("rst_ack",   32'(ack),       32'd0);
        check_val("rst_pulse", 32'(pulse_out), 32'd0);
        check_val("rst_owner", 32'(owner),     32'd0);
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_done",  32'(done),      32'd0);

        // Single request, dur0=3
        set_dur(3, 7, 7, 7);
        req = 4'b0001;
        tick();
        check_val("s1_ack",   32'(ack),       32'h1);
        check_val("s1_pulse", 32'(pulse_out), 32'd1);
        check_val("s1_owner", 32'(owner),     32'd0);
        check_val("s1_busy",  32'(busy),      32'd1);
        req = 4'b0000;
        set_dur(9, 9, 9, 9);
        tick();
        check_val("s2_ack",   32'(ack),       32'h0);
        check_val("s2_pulse", 32'(pulse_out), 32'd1);
        tick();
        check_val("s3_pulse", 32'(pulse_out), 32'd1);
        check_val("s3_done",  32'(done),      32'd0);
        tick();
        check_val("s4_pulse", 32'(pulse_out), 32'd0);
        check_val("s4_done",  32'(done),      32'd1);
        check_val("s4_busy",  32'(busy),      32'(GAP_ON));
        check_val("s4_owner", 32'(owner),     32'd0);
        tick();
        check_val("s5_done",  32'(done),      32'd0);

        // Zero duration on requester 1
        do_reset();
        set_dur(5, 0, 5, 5);
        req = 4'b0010;
        tick();
        check_val("z1_ack",   32'(ack),       32'h2);
        check_val("z1_pulse", 32'(pulse_out), 32'd1);
        check_val("z1_owner", 32'(owner),     32'd1);
        req = 4'b0000;
        tick();
        check_val("z2_pulse", 32'(pulse_out), 32'd0);
        check_val("z2_done",  32'(done),      32'd1);
        tick();
        check_val("z3_done",  32'(done),      32'd0);

        // Reset in the 3rd cycle of a 10-cycle pulse
        do_reset();
        set_dur(1, 1, 10, 1);
        req = 4'b0100;
        tick();
        check_val("r1_ack",   32'(ack),   32'h4);
        check_val("r1_owner", 32'(owner), 32'd2);
        req = 4'b0000;
        tick();
        tick();
        check_val("r3_pulse", 32'(pulse_out), 32'd1);
        reset = 1'b1;
        tick();
        check_val("r4_pulse", 32'(pulse_out), 32'd0);
        check_val("r4_busy",  32'(busy),      32'd0);
        check_val("r4_done",  32'(done),      32'd0);
        check_val("r4_owner", 32'(owner),     32'd0);
        reset = 1'b0;
        req = 4'b1111;
        tick();
        check_val("r5_ack",   32'(ack),   32'h1);
        check_val("r5_owner", 32'(owner), 32'd0);
        req = 4'b0000;
        tick();
        check_val("r6_done",  32'(done),  32'd1);

`ifndef PULSE_ARB_GAP_EN
        // All four held, dur=2: order 0,1,2,3,0 with period 3
        do_reset();
        set_dur(2, 2, 2, 2);
        req = 4'b1111;
        for (int t = 1; t <= 15; t++) begin
            tick();
            phase = (t - 1) % 3;
            check_val("rr_pulse", 32'(pulse_out), (phase != 2) ? 32'd1 : 32'd0);
            check_val("rr_done",  32'(done),      (phase == 2) ? 32'd1 : 32'd0);
            if (phase == 0) begin
                exp_g = ((t - 1) / 3) % 4;
                check_val("rr_ack",   32'(ack),   32'd1 << exp_g);
                check_val("rr_owner", 32'(owner), 32'(exp_g));
            end else begin
                check_val("rr_noack", 32'(ack), 32'd0);
            end
            if (t == 15) req = 4'b0000;
        end
        tick();
        check_val("rr_idle_busy", 32'(busy), 32'd0);

        // req[0] and req[2] held, dur=5: owners alternate 0,2,0,2
        do_reset();
        set_dur(5, 5, 5, 5);
        req = 4'b0101;
        stray_ack = '0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            phase = (t - 1) % 6;
            stray_ack = stray_ack | (ack & 4'b1010);
            check_val("alt_pulse", 32'(pulse_out), (phase < 5) ? 32'd1 : 32'd0);
            check_val("alt_done",  32'(done),      (phase == 5) ? 32'd1 : 32'd0);
            if (phase == 0) begin
                exp_g = (((t - 1) / 6) % 2) * 2;
                check_val("alt_ack",   32'(ack),   32'd1 << exp_g);
                check_val("alt_owner", 32'(owner), 32'(exp_g));
            end else begin
                check_val("alt_noack", 32'(ack), 32'd0);
            end
            if (t == 24) req = 4'b0000;
        end
        check_val("alt_stray", 32'(stray_ack), 32'd0);
`else
        // GAP=4, req[1] held, dur1=2: 2 high, 5 low, busy low 1 cycle
        do_reset();
        set_dur(1, 2, 1, 1);
        req = 4'b0010;
        for (int t = 1; t <= 21; t++) begin
            tick();
            phase = (t - 1) % 7;
            check_val("gap_pulse", 32'(pulse_out), (phase < 2) ? 32'd1 : 32'd0);
            check_val("gap_busy",  32'(busy),      (phase != 6) ? 32'd1 : 32'd0);
            check_val("gap_done",  32'(done),      (phase == 2) ? 32'd1 : 32'd0);
            if (t == 21) req = 4'b0000;
        end
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
